// File: rtl/del_line_ctrl.sv
// del_line_ctrl: sequencer for a chain of ce-gated delay lines of depth LATENCY.
// Produces the shared clock enable from the pixel stream, tracks valid/end-of-line
// tags alongside the datapath and flushes the pipeline after the last pixel of a line.
module del_line_ctrl #(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_de,
    input  logic             i_eol,
    output logic             rdy,
    output logic             ce,
    output logic             o_de,
    output logic             o_eol,
    output logic [CNT_W-1:0] o_len,
    output logic             busy,
    output logic             ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [7:0]       FLUSH_INIT = 8'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]       state;
    logic [7:0]       flush_cnt;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pix_inc;
    logic             flushing;
    logic             acc;
    logic             top_vld;
    logic             top_eol;

    assign flushing = (state == FLUSH);
    assign rdy      = !flushing && !rst;
    assign acc      = i_de && rdy;
    assign ce       = !rst && (acc || flushing);
    assign busy     = (state != IDLE);
    assign pix_inc  = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + 1'b1;

    // The o_de/o_eol registers form the final stage, so only LATENCY-1 tag stages are kept here.
    if (LATENCY == 1) begin : g_direct
        assign top_vld = acc;
        assign top_eol = acc && i_eol;
    end else begin : g_tags
        logic [LATENCY-2:0] vld_sr;
        logic [LATENCY-2:0] eol_sr;

        // Tag shift registers advance together with the datapath on ce.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_sr <= '0;
                eol_sr <= '0;
            end else if (ce) begin
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    vld_sr[i] <= vld_sr[i-1];
                    eol_sr[i] <= eol_sr[i-1];
                end
                vld_sr[0] <= acc;
                eol_sr[0] <= acc && i_eol;
            end
        end

        assign top_vld = vld_sr[LATENCY-2];
        assign top_eol = eol_sr[LATENCY-2];
    end

    // Output strobes: a tagged pixel reaches the delay-line outputs on this ce pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_de  <= 1'b0;
            o_eol <= 1'b0;
        end else begin
            o_de  <= ce && top_vld;
            o_eol <= ce && top_eol;
        end
    end

    // Line state machine: open a line on the first pixel, flush after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (acc && i_eol) begin
                        if (LATENCY == 1) begin
                            state <= IDLE;
                        end else begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_INIT;
                        end
                    end else if (acc) begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == 8'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating pixel counter; latches the line length at end of line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
            o_len   <= '0;
        end else if (acc) begin
            if (i_eol) begin
                o_len   <= pix_inc;
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_inc;
            end
        end
    end

    // Sticky overflow: a pixel was offered while the source was held off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (i_de && !rdy) begin
            ovf <= 1'b1;
        end
    end

endmodule
